bcd_seq_update_sequencer: RTL and testbench

BCD_SEQ_UPDATE_SEQUENCER -- requirements
Module: bcd_seq_update_sequencer

---
 rtl/bcd_seq_update_sequencer.sv | 125 ++++++++++++
 tb/tb_bcd_seq_update_sequencer.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/bcd_seq_update_sequencer.sv
// Converts a two's-complement value to sign + packed BCD by serial double-dabble,
// then publishes the result only on a display frame boundary.
module bcd_seq_update_sequencer #(
  parameter int SEQ_LEN    = 20,
  parameter int BCD_DIGITS = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic [SEQ_LEN-1:0]      in_data,
  output logic                    in_ready,
  input  logic                    frame_tick,
  output logic [BCD_DIGITS*4-1:0] bcd_out,
  output logic                    neg_out,
  output logic [BCD_DIGITS-1:0]   lz_mask,
  output logic                    upd_done
);

  localparam int ACC_W = BCD_DIGITS * 4;
  localparam int CNT_W = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;
  localparam logic [BCD_DIGITS-1:0] LZ_RST = {{(BCD_DIGITS-1){1'b1}}, 1'b0};

  typedef enum logic [1:0] {IDLE, SHIFT, WAIT_FRAME, COMMIT} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [SEQ_LEN-1:0] mag_q, mag_d;
  logic              sign_q, sign_d;
  logic [ACC_W-1:0]  bcd_q, bcd_d;
  logic              neg_q, neg_d;
  logic [BCD_DIGITS-1:0] lz_q, lz_d;
  logic              upd_done_q, upd_done_d;
  logic              in_ready_q, in_ready_d;

  logic [ACC_W-1:0]      acc_adj;
  logic [BCD_DIGITS-1:0] digit_zero;
  logic [BCD_DIGITS-1:0] lz_new;

  // Per-digit +3 correction and leading-zero detection on the accumulator
  for (genvar gi = 0; gi < BCD_DIGITS; gi++) begin : g_digit
    assign acc_adj[gi*4 +: 4] = (acc_q[gi*4 +: 4] >= 4'd5) ? acc_q[gi*4 +: 4] + 4'd3
                                                           : acc_q[gi*4 +: 4];
    assign digit_zero[gi] = (acc_q[gi*4 +: 4] == 4'd0);
    if (gi == 0) begin : g_lz0
      assign lz_new[gi] = 1'b0;
    end else begin : g_lzn
      assign lz_new[gi] = &digit_zero[BCD_DIGITS-1:gi];
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    mag_d      = mag_q;
    sign_d     = sign_q;
    bcd_d      = bcd_q;
    neg_d      = neg_q;
    lz_d       = lz_q;
    upd_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sign_d  = in_data[SEQ_LEN-1];
          // Negating the most-negative value yields 2^(SEQ_LEN-1) when read unsigned
          mag_d   = in_data[SEQ_LEN-1] ? (~in_data + 1'b1) : in_data;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        {acc_d, mag_d} = {acc_adj, mag_q} << 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(SEQ_LEN - 1)) state_d = WAIT_FRAME;
      end
      WAIT_FRAME: begin
        if (frame_tick) state_d = COMMIT;
      end
      COMMIT: begin
        bcd_d      = acc_q;
        neg_d      = sign_q && (acc_q != '0);
        lz_d       = lz_new;
        upd_done_d = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
    in_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      mag_q      <= '0;
      sign_q     <= 1'b0;
      bcd_q      <= '0;
      neg_q      <= 1'b0;
      lz_q       <= LZ_RST;
      upd_done_q <= 1'b0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      mag_q      <= mag_d;
      sign_q     <= sign_d;
      bcd_q      <= bcd_d;
      neg_q      <= neg_d;
      lz_q       <= lz_d;
      upd_done_q <= upd_done_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready = in_ready_q;
  assign bcd_out  = bcd_q;
  assign neg_out  = neg_q;
  assign lz_mask  = lz_q;
  assign upd_done = upd_done_q;

endmodule

// File: tb/tb_bcd_seq_update_sequencer.sv
// Randomized scoreboard bench: driver pushes expected displays on accept,
// monitor pops and compares on every upd_done pulse.
module tb_bcd_seq_update_sequencer;
  localparam int SEQ_LEN    = 20;
  localparam int BCD_DIGITS = 6;

  typedef struct packed {
    logic [BCD_DIGITS*4-1:0] bcd;
    logic                    neg;
    logic [BCD_DIGITS-1:0]   lz;
  } disp_t;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    in_valid;
  logic [SEQ_LEN-1:0]      in_data;
  logic                    in_ready;
  logic                    frame_tick;
  logic [BCD_DIGITS*4-1:0] bcd_out;
  logic                    neg_out;
  logic [BCD_DIGITS-1:0]   lz_mask;
  logic                    upd_done;

  int checks   = 0;
  int failures = 0;
  disp_t sb[$];

  bcd_seq_update_sequencer #(.SEQ_LEN(SEQ_LEN), .BCD_DIGITS(BCD_DIGITS)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .frame_tick(frame_tick), .bcd_out(bcd_out), .neg_out(neg_out), .lz_mask(lz_mask),
    .upd_done(upd_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: decimal digits straight from integer arithmetic
  function automatic disp_t model(input logic [SEQ_LEN-1:0] v);
    disp_t  e;
    longint mag, rem, p;
    mag = v[SEQ_LEN-1] ? (longint'(1) << SEQ_LEN) - longint'(v) : longint'(v);
    rem = mag;
    p   = 1;
    e.bcd = '0;
    e.lz  = '0;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      e.bcd[i*4 +: 4] = 4'(rem % 10);
      rem = rem / 10;
      if (i >= 1) e.lz[i] = (mag / p) == 0;
      p = p * 10;
    end
    e.neg = v[SEQ_LEN-1] && (mag != 0);
    return e;
  endfunction

  // Monitor: scoreboard compare on upd_done, plus output stability between commits
  disp_t prev;
  logic  prev_ok = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      prev_ok <= 1'b0;
    end else begin
      if (upd_done) begin
        if (sb.size() == 0) begin
          check("unexpected_upd_done", 1, 0);
        end else begin
          disp_t e;
          e = sb.pop_front();
          check("bcd_out", bcd_out, e.bcd);
          check("neg_out", neg_out, e.neg);
          check("lz_mask", lz_mask, e.lz);
        end
      end else if (prev_ok) begin
        check("outputs_stable", {bcd_out, neg_out, lz_mask}, prev);
      end
      prev_ok <= 1'b1;
    end
    prev <= {bcd_out, neg_out, lz_mask};
  end

  // mode 0: tick held high; 1: random ticks; 2: no tick for 100 wait cycles, then one tick
  task automatic do_txn(input logic [SEQ_LEN-1:0] v, input int mode);
    int c, t;
    logic tk;
    check("in_ready_before_accept", in_ready, 1);
    in_valid   = 1'b1;
    in_data    = v;
    frame_tick = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    @(posedge clk);
    sb.push_back(model(v));
    #1;
    c = 1;
    t = -1;
    forever begin
      case (mode)
        0:       tk = 1'b1;
        1:       tk = ($urandom_range(0, 3) == 0);
        default: tk = (c == SEQ_LEN + 101);
      endcase
      frame_tick = tk;
      if (t < 0 && c >= SEQ_LEN + 1 && tk) t = c;
      check("upd_done_timing", upd_done, (t >= 0 && c == t + 2));
      check("in_ready_timing", in_ready, (t >= 0 && c == t + 2));
      if (t >= 0 && c == t + 2) break;
      if (c > 400) begin
        check("commit_timeout", 0, 1);
        break;
      end
      in_valid = 1'($urandom_range(0, 1));
      in_data  = SEQ_LEN'($urandom);
      @(posedge clk);
      #1;
      c++;
    end
    in_valid   = 1'b0;
    frame_tick = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_bcd"}, bcd_out, 0);
    check({tag, "_neg"}, neg_out, 0);
    check({tag, "_lz"}, lz_mask, {{(BCD_DIGITS-1){1'b1}}, 1'b0});
    check({tag, "_upd"}, upd_done, 0);
    check({tag, "_ready"}, in_ready, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [SEQ_LEN-1:0] v;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; frame_tick = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_reset_vals("reset");

    do_txn(20'd12345, 0);
    do_txn(20'd0, 0);
    do_txn(20'hFFFFF, 0);
    do_txn(20'h80000, 0);
    do_txn(20'd999999 & 20'hFFFFF, 1);
    do_txn(20'h7FFFF, 2);

    // Reset in SHIFT cycle 10 of converting 999
    in_valid = 1'b1; in_data = 20'd999; frame_tick = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check_reset_vals("abort");
    repeat (SEQ_LEN + 5) begin
      @(posedge clk);
      #1 check("abort_no_upd", upd_done, 0);
    end
    frame_tick = 1'b0;

    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 3))
        0:       v = SEQ_LEN'($urandom_range(0, 99));
        1:       v = -SEQ_LEN'($urandom_range(1, 99));
        default: v = SEQ_LEN'($urandom);
      endcase
      do_txn(v, $urandom_range(0, 1));
    end

    repeat (3) @(posedge clk);
    #1 check("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
